crossbar_slave_arbiter: RTL
===========================

Name: crossbar_slave_arbiter

Overview:
- One instance per slave port of the 2-master/2-slave crossbar; shares that slave between master 0 and master 1.
- Decodes `addr[31]` against SLAVE_ID and round-robin arbitrates between the matching requests.
- Forwards the winner's command to the slave and returns ack to the winner.
- Tracks outstanding reads in an in-order ID FIFO, so each slave read response is routed back to the master that issued it.

Parameters:
- SLAVE_ID, 0, value of `master_N_addr[31]` that selects this slave.
- RD_DEPTH, 4, maximum outstanding reads; power of two, 2..16.
- PTR_W, 2, log2(RD_DEPTH); used for the FIFO pointers. The count is PTR_W+1 bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- master_0_req  in  1  request valid, held until ack
- master_0_cmd  in  1  1 = write, 0 = read
- master_0_addr  in  32  bit 31 = slave select, [30:0] = slave address
- master_0_wdata  in  32  write data
- master_0_ack  out  1  request accepted this cycle
- master_0_rdata  out  32  read data; 0 when master_0_resp = 0
- master_0_resp  out  1  read data valid
- master_1_req, master_1_cmd, master_1_addr, master_1_wdata, master_1_ack, master_1_rdata, master_1_resp  as for master 0
- slave_req  out  1  request to slave
- slave_cmd  out  1  forwarded cmd
- slave_addr  out  31  forwarded `addr[30:0]`
- slave_wdata  out  32  forwarded wdata
- slave_ack  in  1  slave accepts current request
- slave_rdata  in  32  slave read data
- slave_resp  in  1  slave read data valid, one cycle per read, in order
- rd_outstanding  out  PTR_W+1  read FIFO occupancy
- err_unexp_resp  out  1  sticky: slave_resp seen with FIFO empty

Behaviour:
- Decode: `hit_N = master_N_req & (master_N_addr[31] == SLAVE_ID)`.
- Eligibility: `elig_N = hit_N & (master_N_cmd | ~full)`. Writes are never blocked by FIFO state; reads are blocked while full.
- Arbitration (combinational): register `prio` (0 or 1, reset 0) names the preferred master.
  - Both eligible: grant = prio.
  - One eligible: grant = that one.
  - None eligible: no grant.
- Slave outputs:
  - `slave_req = any eligible & ~rst`.
  - slave_cmd/addr/wdata = granted master's fields; all 0 when no grant.
- Ack: `master_g_ack = slave_req & slave_ack & (grant == g)`, combinational. The other master's ack = 0.
- Handshake = slave_req & slave_ack at a rising edge. On handshake:
  - prio <= ~grant (alternates per accepted transfer). prio is unchanged without a handshake.
  - A master holding req through consecutive cycles against a competitor is therefore served every other transfer.
- Read FIFO:
  - Width 1 (master ID), depth RD_DEPTH.
  - Push the grant ID on a read handshake.
  - Pop on slave_resp when not empty.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - `full` is evaluated from registered occupancy, so a read is blocked when full even if a pop occurs that cycle.
  - rd_outstanding = occupancy.
- Response routing (combinational):
  - On slave_resp with FIFO not empty, head ID h drives `master_h_resp = 1` and `master_h_rdata = slave_rdata`.
  - The other master gets resp 0, rdata 0.
- Unexpected response: slave_resp with the FIFO empty (including the same cycle as the first push) → response dropped, no master resp, err_unexp_resp <= 1 until rst.
- Latency: 0 cycles request-to-slave and ack; response routing 0 cycles after slave_resp.
- Slave contract: no read response earlier than the cycle after acceptance.
- Reset values (async, immediate): prio = 0, FIFO empty, rd_outstanding = 0, err_unexp_resp = 0, all acks/resps/slave_req = 0, rdata = 0.
- Reset mid-transaction discards outstanding IDs. Later slave_resp for those reads sets err_unexp_resp.
- Address MSB mismatch: the request is ignored entirely; the other arbiter instance serves it.

Test Plan:
- Single write: m0 req=1, cmd=1, addr=0x00000001, wdata=1, slave_ack=1 → same cycle slave_req=1, slave_addr=1, slave_wdata=1, master_0_ack=1, master_1_ack=0; rd_outstanding stays 0.
- Read routing: m1 reads addr 0x00000003; slave returns resp with rdata=9 two cycles later → master_1_resp=1, master_1_rdata=9, master_0_resp=0, master_0_rdata=0; rd_outstanding goes 1 then 0.
- Contention: both masters hold read req to addrs 1, 2, 3 for 6 cycles, slave_ack always 1 → grant sequence m0,m1,m0,m1,m0,m1 after reset; slave responses 10..15 delivered in order, alternating m0/m1.
- Back-pressure: RD_DEPTH=4, slave never responds, m0 issues 6 reads → 4 acks, then slave_req=0 for reads; a write from m1 during stall acks immediately; one slave_resp re-enables reads on the next cycle.
- Decode: m0 addr=0x80000001 on SLAVE_ID=0 instance → slave_req=0, no ack; same stimulus on SLAVE_ID=1 instance → slave_addr=0x00000001, ack.
- Errors/reset: slave_resp with FIFO empty → no master resp, err_unexp_resp=1 sticky. Assert rst with 2 reads outstanding → rd_outstanding=0, prio=0, err cleared immediately.

Source files
------------

// File: rtl/crossbar_slave_arbiter.sv
// crossbar_slave_arbiter: shares one crossbar slave between two masters with
// round-robin arbitration and in-order read response routing.
module crossbar_slave_arbiter #(
  parameter logic SLAVE_ID = 1'b0,
  parameter int   RD_DEPTH = 4,
  parameter int   PTR_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             master_0_req,
  input  logic             master_0_cmd,
  input  logic [31:0]      master_0_addr,
  input  logic [31:0]      master_0_wdata,
  output logic             master_0_ack,
  output logic [31:0]      master_0_rdata,
  output logic             master_0_resp,
  input  logic             master_1_req,
  input  logic             master_1_cmd,
  input  logic [31:0]      master_1_addr,
  input  logic [31:0]      master_1_wdata,
  output logic             master_1_ack,
  output logic [31:0]      master_1_rdata,
  output logic             master_1_resp,
  output logic             slave_req,
  output logic             slave_cmd,
  output logic [30:0]      slave_addr,
  output logic [31:0]      slave_wdata,
  input  logic             slave_ack,
  input  logic [31:0]      slave_rdata,
  input  logic             slave_resp,
  output logic [PTR_W:0]   rd_outstanding,
  output logic             err_unexp_resp
);
  logic                prio, full, empty, elig_0, elig_1, any, grant, hs, push, pop, head;
  logic [RD_DEPTH-1:0] ids;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;

  // depth is a power of two, so the count MSB alone marks full
  assign full   = count[PTR_W];
  assign empty  = count == '0;
  assign elig_0 = master_0_req & (master_0_addr[31] == SLAVE_ID) & (master_0_cmd | ~full);
  assign elig_1 = master_1_req & (master_1_addr[31] == SLAVE_ID) & (master_1_cmd | ~full);
  assign any    = elig_0 | elig_1;
  assign grant  = (elig_0 & elig_1) ? prio : elig_1;

  assign slave_req   = any & ~rst;
  assign slave_cmd   = any & (grant ? master_1_cmd : master_0_cmd);
  assign slave_addr  = any ? (grant ? master_1_addr[30:0] : master_0_addr[30:0]) : '0;
  assign slave_wdata = any ? (grant ? master_1_wdata : master_0_wdata) : '0;

  assign hs           = slave_req & slave_ack;
  assign master_0_ack = hs & ~grant;
  assign master_1_ack = hs & grant;

  assign push = hs & ~slave_cmd;
  assign pop  = slave_resp & ~empty;
  assign head = ids[rd_ptr];

  assign master_0_resp  = pop & ~head;
  assign master_1_resp  = pop & head;
  assign master_0_rdata = master_0_resp ? slave_rdata : '0;
  assign master_1_rdata = master_1_resp ? slave_rdata : '0;
  assign rd_outstanding = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio           <= 1'b0;
      ids            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_unexp_resp <= 1'b0;
    end else begin
      if (hs) prio <= ~grant;
      if (push) begin
        ids[wr_ptr] <= grant;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count          <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      err_unexp_resp <= err_unexp_resp | (slave_resp & empty);
    end
  end
endmodule
